// File: rtl/instruction_fetch.sv
// Sequential instruction fetch into a 2-deep {instr,pc} queue; first valid 2 cycles after reset or redirect.
// Stalls issue when queue + in-flight would exceed 2; redirect flushes and overrides everything.
module instruction_fetch #(
   parameter int                    ADDR_WIDTH = 10,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   input  logic [DATA_WIDTH-1:0] imem_data_i,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
   output logic                  instr_valid_o,
   input  logic                  instr_ready_i,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [ADDR_WIDTH-1:0] pc_o
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] instr;
      logic [ADDR_WIDTH-1:0] pc;
   } entry_t;

   logic [ADDR_WIDTH-1:0] r_pc_q;
   logic [ADDR_WIDTH-1:0] r_rsp_pc;
   logic                  r_inflight;
   logic [1:0]            r_cnt;
   entry_t                r_head;
   entry_t                r_tail;

   logic                  w_pop;
   logic                  w_push;
   logic                  w_issue;
   logic [2:0]            w_occ;
   logic [ADDR_WIDTH-1:0] w_fetch_addr;
   entry_t                w_new;
   logic                  w_unused_lsbs;

   // Redirect targets are word aligned; the low bits are dropped on purpose.
   assign w_unused_lsbs = ^redirect_pc_i[1:0];
   assign w_fetch_addr  = redirect_i ? {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00} : r_pc_q;
   assign imem_addr_o   = w_fetch_addr;

   assign instr_valid_o = (r_cnt != 2'd0);
   assign instr_o       = r_head.instr;
   assign pc_o          = r_head.pc;

   assign w_pop   = instr_valid_o & instr_ready_i;
   assign w_push  = r_inflight & ~redirect_i;
   assign w_occ   = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue = redirect_i | (w_occ < 3'd2);
   assign w_new   = '{instr: imem_data_i, pc: r_rsp_pc};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pc_q     <= RESET_PC;
         r_rsp_pc   <= '0;
         r_inflight <= 1'b0;
         r_cnt      <= 2'd0;
         r_head     <= '0;
         r_tail     <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_rsp_pc <= w_fetch_addr;
            r_pc_q   <= w_fetch_addr + ADDR_WIDTH'(4);
         end
         if (redirect_i) begin
            r_cnt <= 2'd0;
         end else begin
            // Head-shift queue: entry 0 is always the presented instruction.
            case ({w_push, w_pop})
               2'b11: begin
                  if (r_cnt == 2'd2) begin
                     r_head <= r_tail;
                     r_tail <= w_new;
                  end else begin
                     r_head <= w_new;
                  end
               end
               2'b10: begin
                  if (r_cnt == 2'd0) r_head <= w_new;
                  else               r_tail <= w_new;
                  r_cnt <= r_cnt + 2'd1;
               end
               2'b01: begin
                  r_head <= r_tail;
                  r_cnt  <= r_cnt - 2'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a 1-cycle-latency ROM whose word k holds k.
module tb_instruction_fetch;
   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_data;
   logic          redirect;
   logic [AW-1:0] redirect_pc;
   logic          valid;
   logic          ready;
   logic [DW-1:0] instr;
   logic [AW-1:0] pc;

   int n_vec = 0;
   int n_err = 0;

   instruction_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC('0)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .imem_addr_o   (imem_addr),
      .imem_data_i   (imem_data),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .instr_valid_o (valid),
      .instr_ready_i (ready),
      .instr_o       (instr),
      .pc_o          (pc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) imem_data <= {24'b0, imem_addr[9:2]};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_instr(input string tag, input logic [31:0] k, input logic [31:0] p);
      chk({tag, ".valid"}, {31'b0, valid}, 32'd1);
      chk({tag, ".instr"}, instr, k);
      chk({tag, ".pc"}, {22'b0, pc}, p);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
      #3;
      chk("rst.valid", {31'b0, valid}, 32'd0);
      chk("rst.instr", instr, 32'd0);
      chk("rst.pc", {22'b0, pc}, 32'd0);
      chk("rst.addr", {22'b0, imem_addr}, 32'd0);

      // Streaming with ready held high
      do_reset();
      #1;
      chk("s1.c0.addr", {22'b0, imem_addr}, 32'h000);
      chk("s1.c0.valid", {31'b0, valid}, 32'd0);
      cyc(); #1;
      chk("s1.c1.addr", {22'b0, imem_addr}, 32'h004);
      chk("s1.c1.valid", {31'b0, valid}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         cyc(); #1;
         expect_instr("s1.stream", k, 4 * k);
      end

      // Backpressure from cycle 2 for five cycles
      do_reset();
      ready = 1'b0;
      cyc();
      cyc();
      for (int i = 0; i < 5; i++) begin
         #1;
         expect_instr("s2.hold", 0, 0);
         if (i == 4) chk("s2.addr_stalled", {22'b0, imem_addr}, 32'h008);
         cyc();
      end
      ready = 1'b1;
      #1;
      expect_instr("s2.resume", 0, 0);
      for (int k = 1; k < 4; k++) begin
         cyc(); #1;
         expect_instr("s2.resume", k, 4 * k);
      end

      // Fill the queue, then redirect to a misaligned target
      cyc(); ready = 1'b0; #1;
      expect_instr("s3.fill", 4, 32'h010);
      cyc(); #1;
      expect_instr("s3.full", 4, 32'h010);
      chk("s3.full.addr", {22'b0, imem_addr}, 32'h018);
      cyc(); redirect = 1'b1; redirect_pc = 10'h103; ready = 1'b1; #1;
      chk("s3.redir.addr", {22'b0, imem_addr}, 32'h100);
      cyc(); redirect = 1'b0; #1;
      chk("s3.flush.valid", {31'b0, valid}, 32'd0);
      cyc(); #1;
      expect_instr("s3.tgt0", 64, 32'h100);
      cyc(); #1;
      expect_instr("s3.tgt1", 65, 32'h104);

      // Back-to-back redirects; only the second stream survives
      cyc(); redirect = 1'b1; redirect_pc = 10'h040; #1;
      chk("s4.r1.addr", {22'b0, imem_addr}, 32'h040);
      cyc(); redirect_pc = 10'h080; #1;
      chk("s4.r2.addr", {22'b0, imem_addr}, 32'h080);
      chk("s4.r2.valid", {31'b0, valid}, 32'd0);
      cyc(); redirect = 1'b0; #1;
      chk("s4.gap.valid", {31'b0, valid}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         cyc(); #1;
         expect_instr("s4.stream", 32 + k, 32'h080 + 4 * k);
      end

      // Wrap at the top of the address space
      cyc(); redirect = 1'b1; redirect_pc = 10'h3FC; #1;
      cyc(); redirect = 1'b0; #1;
      chk("s5.gap.valid", {31'b0, valid}, 32'd0);
      cyc(); #1;
      expect_instr("s5.top", 32'hFF, 32'h3FC);
      cyc(); #1;
      expect_instr("s5.wrap0", 0, 32'h000);
      cyc(); #1;
      expect_instr("s5.wrap1", 1, 32'h004);

      // Reset pulse while the queue is full
      cyc(); ready = 1'b0; #1;
      expect_instr("s6.fill", 2, 32'h008);
      cyc(); #1;
      expect_instr("s6.full", 2, 32'h008);
      rst_n = 1'b0; #1;
      chk("s6.rst.valid", {31'b0, valid}, 32'd0);
      chk("s6.rst.instr", instr, 32'd0);
      chk("s6.rst.pc", {22'b0, pc}, 32'd0);
      chk("s6.rst.addr", {22'b0, imem_addr}, 32'd0);
      cyc(); ready = 1'b1; rst_n = 1'b1; #1;
      chk("s6.c0.valid", {31'b0, valid}, 32'd0);
      chk("s6.c0.addr", {22'b0, imem_addr}, 32'h000);
      cyc(); #1;
      chk("s6.c1.valid", {31'b0, valid}, 32'd0);
      cyc(); #1;
      expect_instr("s6.c2", 0, 32'h000);
      cyc(); #1;
      expect_instr("s6.c3", 1, 32'h004);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning byte-address width of the instruction memory port and PC.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning first fetch byte address after reset.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port imem_addr_o  output  ADDR_WIDTH  byte address to instruction memory, which returns data one clock after sampling it.
REQ-007 SHALL have port imem_data_i  input  DATA_WIDTH  instruction memory read data.
REQ-008 SHALL have port redirect_i  input  1  branch/jump redirect strobe.
REQ-009 SHALL have port redirect_pc_i  input  ADDR_WIDTH  redirect target byte address.
REQ-010 SHALL have port instr_valid_o  output  1  instr_o/pc_o hold a valid instruction.
REQ-011 SHALL have port instr_ready_i  input  1  downstream accepts the instruction.
REQ-012 SHALL have port instr_o  output  DATA_WIDTH  fetched instruction.
REQ-013 SHALL have port pc_o  output  ADDR_WIDTH  byte address of instr_o.

Function
REQ-014 SHALL hold a next-fetch pointer pc_q, a 1-bit in-flight flag with its address rsp_pc_q, and a 2-entry FIFO of {instruction, pc}.
REQ-015 SHALL drive imem_addr_o combinationally: redirect_pc_i with bits [1:0] forced to 0 when redirect_i=1, otherwise pc_q.
REQ-016 SHALL define pop = instr_valid_o & instr_ready_i and issue = redirect_i | ((count + inflight - pop) < 2).
REQ-017 SHALL, on issue, set inflight=1, rsp_pc_q=imem_addr_o, and pc_q=imem_addr_o+4 modulo 2^ADDR_WIDTH; otherwise inflight=0 and pc_q unchanged.
REQ-018 SHALL, when inflight=1 and redirect_i=0, push {imem_data_i, rsp_pc_q} into the FIFO at the clock edge.
REQ-019 SHALL present the FIFO head on instr_o/pc_o with instr_valid_o = (count != 0); outputs SHALL stay stable while instr_valid_o=1 and instr_ready_i=0.
REQ-020 SHALL perform push and pop in the same cycle without loss or reordering; count SHALL never exceed 2 (issue rule guarantees a free slot).
REQ-021 SHALL, on redirect_i=1, flush the FIFO (count=0), discard the response returning that cycle, and ignore instr_ready_i; instr_valid_o SHALL be 0 in the following cycle.
REQ-022 SHALL give instr_valid_o=1 for the redirect target two cycles after the redirect cycle.
REQ-023 SHALL, with instr_ready_i held 1, deliver one instruction per cycle with sequential pc_o (+4, wrapping from 2^ADDR_WIDTH-4 to 0).
REQ-024 SHALL give redirect_i priority over every other event, including a simultaneous pop, push, or full FIFO.

Reset
REQ-025 SHALL, while rst_ni=0, asynchronously set pc_q=RESET_PC, inflight=0, count=0, instr_valid_o=0, instr_o=0, pc_o=0.
REQ-026 SHALL issue RESET_PC in the first cycle with rst_ni=1 (cycle 0); first instr_valid_o=1 in cycle 2.
REQ-027 SHALL, on reset assertion mid-operation, drop all FIFO contents and in-flight data with no partial instruction emitted after release.

Verification
REQ-028 Reset then ready=1, ROM word k = k -> cycle 2 onward instr_o=0,1,2,3,... with pc_o=0x000,0x004,0x008,... one per cycle.
REQ-029 Ready=0 from cycle 2 for 5 cycles -> instr_o=0/pc_o=0 held stable, FIFO fills to 2, issue stops; ready=1 -> 0,1,2,... with no gap or duplicate.
REQ-030 Redirect to 0x103 while FIFO full and ready=1 -> imem_addr_o=0x100 that cycle, instr_valid_o=0 next cycle, then pc_o=0x100 (word 64), 0x104 (word 65).
REQ-031 Redirect on back-to-back cycles to 0x040 then 0x080 -> only 0x080-stream instructions (word 32 onward) emitted; no 0x040 instruction.
REQ-032 Redirect to 0x3FC, ready=1 -> pc_o=0x3FC then 0x000 (wrap).
REQ-033 rst_ni low for one cycle while FIFO holds 2 -> instr_valid_o=0 immediately; after release, restart at RESET_PC with first valid in cycle 2.
